ps2_host_tx: RTL

Host-to-device transmitter for the PS/2 keyboard port. It sends one command byte to the keyboard, such as LED set (0xED), reset (0xFF) or typematic (0xF3). It sits beside the existing PS/2 receive path in the terminal and shares the open-drain ps2_clk/ps2_data pins with it. The transmitter drives each pin only through an output-enable that pulls the pin low; the receiver is held off while `busy` is high.

---
 rtl/ps2_host_tx_pkg.sv | 28 ++
 rtl/ps2_falldet.sv | 43 ++++
 rtl/ps2_host_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_pkg
//   Constants shared by the PS/2 host transmitter and the receive path:
//   - PS/2 protocol timing in microseconds (inhibit, start and frame timeouts)
//   - keyboard command codes and the device acknowledge code
//   - us_to_cycles(): converts a microsecond duration into inclk cycles
// -----------------------------------------------------------------------------
package ps2_host_tx_pkg;

   // Protocol timing, microseconds
   localparam int unsigned PS2_INHIBIT_US   = 100;    // clock held low before the request
   localparam int unsigned PS2_START_TMO_US = 15000;  // request to first device clock edge
   localparam int unsigned PS2_FRAME_TMO_US = 2000;   // first device clock edge to ACK

   // Keyboard command set
   localparam logic [7:0] PS2_CMD_SET_LEDS  = 8'hED;
   localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
   localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
   localparam logic [7:0] PS2_RESP_ACK      = 8'hFA;

   // Cycle count for a duration; the product is formed in 64 bits because
   // 15000 us at 50 MHz already exceeds the 32-bit range before the divide.
   function automatic logic [31:0] us_to_cycles(input int unsigned us,
                                                input int unsigned hz);
      return 32'((64'(us) * 64'(hz)) / 64'd1_000_000);
   endfunction

endpackage

// File: rtl/ps2_falldet.sv
// -----------------------------------------------------------------------------
// ps2_falldet
//   Two-flop synchronizer for one raw PS/2 pin plus a falling-edge strobe.
//   Ports:
//     inclk        in   system clock
//     async_reset  in   asynchronous, active-high reset
//     pin_i        in   raw, asynchronous pin level
//     level        out  synchronized pin level
//     fall         out  one-cycle strobe, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module ps2_falldet (
   input  logic inclk,
   input  logic async_reset,
   input  logic pin_i,
   output logic level,
   output logic fall
);

   logic meta;
   logic sync;
   logic sync_d;

   // NOTE: the synchronizer resets to 1 (the idle level of an open-drain bus
   // with pull-up); resetting it to 0 would fabricate a fall strobe as soon as
   // reset releases, which the transmitter would take as a device clock edge.
   always_ff @(posedge inclk or posedge async_reset) begin
      if (async_reset) begin
         meta   <= 1'b1;
         sync   <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         meta   <= pin_i;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign level = sync;
   // Decoded straight from flops so the consumer reacts on the very next edge:
   // pin edge -> 2 synchronizer cycles -> 1 registered response cycle.
   assign fall  = sync_d & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device transmitter for the PS/2 keyboard port. Sends one command
//   byte (start bit, 8 data bits LSB first, odd parity, stop) and checks the
//   device acknowledge. Pins are open drain: the block only ever pulls low
//   through the *_oe outputs. The receive path is held off while busy is high.
//   Ports:
//     inclk        in   system clock
//     async_reset  in   asynchronous, active-high reset
//     data[7:0]    in   byte to send, captured when start is accepted
//     start        in   one-cycle request, accepted only in IDLE
//     busy         out  high from accepted start until done
//     done         out  one-cycle pulse at end of transfer
//     error        out  with done: 1 = timeout or NACK; 0 whenever done is 0
//     ps2_clk_i    in   raw clock pin level
//     ps2_data_i   in   raw data pin level
//     ps2_clk_oe   out  1 = pull clock pin low
//     ps2_data_oe  out  1 = pull data pin low
// -----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned INCLK        = 50_000_000,
   parameter int unsigned INHIBIT_US   = PS2_INHIBIT_US,
   parameter int unsigned START_TMO_US = PS2_START_TMO_US,
   parameter int unsigned FRAME_TMO_US = PS2_FRAME_TMO_US
) (
   input  logic       inclk,
   input  logic       async_reset,
   input  logic [7:0] data,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   // Last timer value of each phase; the timer starts at 0 on phase entry, so
   // a phase of N cycles ends when the timer reads N-1.
   localparam logic [31:0] INHIBIT_LAST = us_to_cycles(INHIBIT_US,   INCLK) - 32'd1;
   localparam logic [31:0] START_LAST   = us_to_cycles(START_TMO_US, INCLK) - 32'd1;
   localparam logic [31:0] FRAME_LAST   = us_to_cycles(FRAME_TMO_US, INCLK) - 32'd1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_WAIT1,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_FIN,
      S_FAIL
   } state_t;

   state_t      state;
   logic [31:0] timer;
   logic [31:0] timer_inc;
   logic [7:0]  shreg;      // data bits not yet driven, next one in bit 0
   logic        parity_q;
   logic [3:0]  bit_idx;    // 0..7 data, 8 parity, 9 stop
   logic        nack_q;     // data level sampled on the ACK fall
   logic        fail_req;

   logic        clk_s;
   logic        clk_fall;
   logic        data_s;
   logic        data_fall_unused;

   ps2_falldet u_clk_det (
      .inclk       (inclk),
      .async_reset (async_reset),
      .pin_i       (ps2_clk_i),
      .level       (clk_s),
      .fall        (clk_fall)
   );

   // Only the synchronized level of the data line is of interest.
   ps2_falldet u_data_det (
      .inclk       (inclk),
      .async_reset (async_reset),
      .pin_i       (ps2_data_i),
      .level       (data_s),
      .fall        (data_fall_unused)
   );

   // The timer saturates instead of wrapping so a stuck phase can never alias
   // back below its limit.
   assign timer_inc = (timer == '1) ? timer : timer + 32'd1;

   // Every abort condition in one place so the FSM has a single FAIL entry.
   // NOTE: each signal written in always_comb gets a default before the case,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      fail_req = 1'b0;
      case (state)
         S_WAIT1:     fail_req = !clk_fall && (timer == START_LAST);
         S_SHIFT,
         S_WAIT_IDLE: fail_req = (timer >= FRAME_LAST);
         S_ACK:       fail_req = nack_q || (timer >= FRAME_LAST);
         default:     fail_req = 1'b0;
      endcase
   end

   // NOTE: all state and outputs update with non-blocking assignments, so
   // every decision below sees the values from before this edge regardless
   // of statement order.
   always_ff @(posedge inclk or posedge async_reset) begin
      if (async_reset) begin
         state       <= S_IDLE;
         timer       <= '0;
         shreg       <= '0;
         parity_q    <= 1'b0;
         bit_idx     <= '0;
         nack_q      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         timer <= timer_inc;

         if (fail_req) begin
            // Release both lines on the same edge that reports the failure.
            state       <= S_FAIL;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            error       <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     shreg       <= data;
                     parity_q    <= ~^data;
                     timer       <= '0;
                     busy        <= 1'b1;
                     ps2_clk_oe  <= 1'b1;
                     ps2_data_oe <= 1'b0;
                     state       <= S_INHIBIT;
                  end
               end

               S_INHIBIT: begin
                  if (timer == INHIBIT_LAST) begin
                     ps2_data_oe <= 1'b1;          // start bit, clock still held
                     state       <= S_REQ;
                  end
               end

               S_REQ: begin
                  ps2_clk_oe <= 1'b0;              // hand the clock to the device
                  timer      <= '0;
                  state      <= S_WAIT1;
               end

               S_WAIT1: begin
                  if (clk_fall) begin
                     ps2_data_oe <= ~shreg[0];
                     shreg       <= {1'b0, shreg[7:1]};
                     bit_idx     <= '0;
                     timer       <= '0;           // frame timer starts here
                     state       <= S_SHIFT;
                  end
               end

               S_SHIFT: begin
                  if (clk_fall) begin
                     if (bit_idx == 4'd9) begin
                        nack_q <= data_s;
                        state  <= S_ACK;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                        case (bit_idx)
                           4'd7:    ps2_data_oe <= ~parity_q;
                           4'd8:    ps2_data_oe <= 1'b0;  // stop bit: release
                           default: begin
                              ps2_data_oe <= ~shreg[0];
                              shreg       <= {1'b0, shreg[7:1]};
                           end
                        endcase
                     end
                  end
               end

               S_ACK: begin
                  state <= S_WAIT_IDLE;               // NACK leaves via fail_req
               end

               S_WAIT_IDLE: begin
                  if (clk_s && data_s) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end
               end

               S_FIN, S_FAIL: begin
                  state <= S_IDLE;                    // start is ignored here
               end

               default: begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
